// File: rtl/core_controller_if.sv
// Bundle between the execute-path sequencer and the fetch stage, decoder, LSU and PC/RF write logic.
// The controller side uses the master modport; the surrounding pipeline uses slave.
interface core_controller_if;
   logic        instr_valid_i;
   logic        instr_ready_o;
   logic        illegal_inst_i;
   logic        ecall_inst_i;
   logic        ebreak_inst_i;
   logic        mret_inst_i;
   logic        jump_inst_i;
   logic        branch_inst_i;
   logic        lsu_r_en_i;
   logic        lsu_w_en_i;
   logic [31:0] alu_result_i;
   logic        lsu_done_i;
   logic        lsu_req_o;
   logic        cycle_counter_o;
   logic        rf_we_en_o;
   logic        pc_we_o;
   logic [1:0]  pc_sel_o;
   logic        trap_o;
   logic [3:0]  trap_cause_o;

   modport master (
      input  instr_valid_i, illegal_inst_i, ecall_inst_i, ebreak_inst_i, mret_inst_i,
             jump_inst_i, branch_inst_i, lsu_r_en_i, lsu_w_en_i, alu_result_i, lsu_done_i,
      output instr_ready_o, lsu_req_o, cycle_counter_o, rf_we_en_o, pc_we_o, pc_sel_o,
             trap_o, trap_cause_o
   );

   modport slave (
      output instr_valid_i, illegal_inst_i, ecall_inst_i, ebreak_inst_i, mret_inst_i,
             jump_inst_i, branch_inst_i, lsu_r_en_i, lsu_w_en_i, alu_result_i, lsu_done_i,
      input  instr_ready_o, lsu_req_o, cycle_counter_o, rf_we_en_o, pc_we_o, pc_sel_o,
             trap_o, trap_cause_o
   );
endinterface

// File: rtl/core_controller.sv
// Multi-cycle sequencer for the BURV execute path: two-cycle jumps/branches, LSU stalls with
// timeout, and trap/MRET redirection of the PC.
module core_controller #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input logic clk,
   input logic rst,
   core_controller_if.master bus
);

   typedef enum logic [1:0] {
      S_DECODE,
      S_EXEC2,
      S_MEM,
      S_TRAP
   } state_t;

   state_t           state_q;
   logic             branch_taken_q;
   logic [CNT_W-1:0] mem_cnt_q;
   logic [3:0]       trap_cause_q;

   logic             trap_req;
   logic             mem_access;
   logic             mem_timeout;

   logic             instr_ready;
   logic             lsu_req;
   logic             cycle_counter;
   logic             rf_we_en;
   logic             pc_we;
   logic [1:0]       pc_sel;
   logic             trap;

   logic             unused_alu_bits;

   assign trap_req    = bus.illegal_inst_i | bus.ecall_inst_i | bus.ebreak_inst_i;
   assign mem_access  = bus.lsu_r_en_i | bus.lsu_w_en_i;
   // The counter holds the index of the current S_MEM cycle, so the last allowed cycle is MEM_TIMEOUT-1.
   assign mem_timeout = (mem_cnt_q == CNT_W'(MEM_TIMEOUT - 1));

   assign unused_alu_bits = ^bus.alu_result_i[31:1];

   // State register plus the flags that must survive into the second cycle of an instruction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_DECODE;
         branch_taken_q <= 1'b0;
         mem_cnt_q      <= '0;
         trap_cause_q   <= 4'd0;
      end else begin
         case (state_q)
            S_DECODE: begin
               if (bus.instr_valid_i) begin
                  if (bus.illegal_inst_i) begin
                     trap_cause_q <= 4'd2;
                     state_q      <= S_TRAP;
                  end else if (bus.ecall_inst_i) begin
                     trap_cause_q <= 4'd11;
                     state_q      <= S_TRAP;
                  end else if (bus.ebreak_inst_i) begin
                     trap_cause_q <= 4'd3;
                     state_q      <= S_TRAP;
                  end else if (bus.mret_inst_i) begin
                     state_q <= S_DECODE;
                  end else if (bus.jump_inst_i) begin
                     state_q <= S_EXEC2;
                  end else if (bus.branch_inst_i) begin
                     branch_taken_q <= bus.alu_result_i[0];
                     state_q        <= S_EXEC2;
                  end else if (mem_access) begin
                     mem_cnt_q <= '0;
                     state_q   <= S_MEM;
                  end
               end
            end
            S_EXEC2: state_q <= S_DECODE;
            S_MEM: begin
               mem_cnt_q <= mem_cnt_q + 1'b1;
               if (bus.lsu_done_i) begin
                  state_q <= S_DECODE;
               end else if (mem_timeout) begin
                  trap_cause_q <= bus.lsu_r_en_i ? 4'd5 : 4'd7;
                  state_q      <= S_TRAP;
               end
            end
            S_TRAP:  state_q <= S_DECODE;
            default: state_q <= S_DECODE;
         endcase
      end
   end

   // Output decode; everything is forced low while reset is held so nothing is written.
   always_comb begin
      instr_ready   = 1'b0;
      lsu_req       = 1'b0;
      cycle_counter = 1'b0;
      rf_we_en      = 1'b0;
      pc_we         = 1'b0;
      pc_sel        = 2'd0;
      trap          = 1'b0;
      if (!rst) begin
         case (state_q)
            S_DECODE: begin
               if (bus.instr_valid_i && !trap_req) begin
                  if (bus.mret_inst_i) begin
                     pc_we       = 1'b1;
                     pc_sel      = 2'd3;
                     instr_ready = 1'b1;
                  end else if (bus.jump_inst_i) begin
                     rf_we_en = 1'b1;
                  end else if (bus.branch_inst_i) begin
                     rf_we_en = 1'b0;
                  end else if (mem_access) begin
                     lsu_req = 1'b1;
                  end else begin
                     rf_we_en    = 1'b1;
                     pc_we       = 1'b1;
                     instr_ready = 1'b1;
                  end
               end
            end
            S_EXEC2: begin
               cycle_counter = 1'b1;
               pc_we         = 1'b1;
               instr_ready   = 1'b1;
               pc_sel        = (bus.jump_inst_i || branch_taken_q) ? 2'd1 : 2'd0;
            end
            S_MEM: begin
               if (bus.lsu_done_i) begin
                  rf_we_en    = bus.lsu_r_en_i;
                  pc_we       = 1'b1;
                  instr_ready = 1'b1;
               end
            end
            S_TRAP: begin
               trap        = 1'b1;
               pc_we       = 1'b1;
               pc_sel      = 2'd2;
               instr_ready = 1'b1;
            end
            default: begin
               trap = 1'b0;
            end
         endcase
      end
   end

   assign bus.instr_ready_o   = instr_ready;
   assign bus.lsu_req_o       = lsu_req;
   assign bus.cycle_counter_o = cycle_counter;
   assign bus.rf_we_en_o      = rf_we_en;
   assign bus.pc_we_o         = pc_we;
   assign bus.pc_sel_o        = pc_sel;
   assign bus.trap_o          = trap;
   assign bus.trap_cause_o    = rst ? 4'd0 : trap_cause_q;

endmodule
